// File: rtl/pipeline_pkg.sv
// Shared sizing helpers for buffered pipeline stages.
package pipeline_pkg;

   // Width needed to hold an occupancy value in 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a storage index in 0..depth-1, never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipeline_ptr.sv
// Wrap-around pointer counter: counts 0..DEPTH-1 and wraps, DEPTH need not be a power of 2.
module pipeline_ptr
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [PW-1:0] r_ptr;

   // Advance on inc with wrap at DEPTH-1; reset and clr both return to slot 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (clr) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/pipeline_buffer.sv
// Multi-entry valid/ready pipeline stage: FIFO storage of DEPTH words with
// selectable full-buffer pass-through, occupancy output and synchronous flush.
module pipeline_buffer
   import pipeline_pkg::*;
#(
   parameter int DW        = 256,
   parameter int DEPTH     = 2,
   parameter bit PASS_FULL = 1'b1,
   parameter int CW        = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_data,
   output logic [CW-1:0] o_count
);

   localparam int            PW       = ptr_w(DEPTH);
   // Array rounded up to a power of two so every pointer value is a legal
   // index; slots at or above DEPTH are never addressed.
   localparam int            NSLOT    = 1 << PW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DW-1:0] r_mem [NSLOT];
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_wp;
   logic [PW-1:0] w_rp;
   logic          w_valid;
   logic          w_full;
   logic          w_ready;
   logic          w_push;
   logic          w_pop;

   // Handshake decode; with PASS_FULL a full buffer accepts when the head leaves this cycle.
   always_comb begin
      w_valid = (r_count != '0);
      w_full  = (r_count == FULL_CNT);
      w_ready = !flush && (!w_full || (PASS_FULL && o_ready));
      w_push  = i_valid && w_ready;
      w_pop   = w_valid && o_ready;
   end

   pipeline_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (w_push),
      .ptr   (w_wp)
   );

   pipeline_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (w_pop),
      .ptr   (w_rp)
   );

   // Occupancy: reset beats flush; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Storage write on accepted words only; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[w_wp] <= i_data;
      end
   end

   assign i_ready = w_ready;
   assign o_valid = w_valid;
   assign o_data  = r_mem[w_rp];
   assign o_count = r_count;

endmodule
